tlb_refill_walker: RTL and testbench

Hardware TLB management engine that drives the MMU command/register interface (`mmu_cmd`, `mmu_reg`, `mmu_dataIn`) as its initiator. After reset it invalidates every TLB entry. It then services TLB-miss requests: it fetches the two EntryLo words of the missing page pair from a linear page table in memory and writes a complete entry into the TLB at a round-robin index. It sits between the MMU exception path and the data-memory read port.

---
 rtl/tlb_refill_walker.sv | 197 +++++++++++++++++++
 tb/tb_tlb_refill_walker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_refill_walker.sv
// TLB refill engine: flushes every TLB entry after reset, then services misses by
// reading an EntryLo pair from a linear page table and writing a full entry at a round-robin index.
package tlb_refill_walker_pkg;
   typedef enum logic [1:0] {
      MMU_CMD_NONE      = 2'd0,
      MMU_CMD_WRITE_REG = 2'd1,
      MMU_CMD_WRITE_TLB = 2'd2,
      MMU_CMD_READ_TLB  = 2'd3
   } MMU_CMD_T;

   typedef enum logic [2:0] {
      MMU_REG_INDEX    = 3'd0,
      MMU_REG_ENTRYHI  = 3'd1,
      MMU_REG_PAGEMASK = 3'd2,
      MMU_REG_ENTRYLO0 = 3'd3,
      MMU_REG_ENTRYLO1 = 3'd4
   } MMU_REG_T;
endpackage

module tlb_refill_walker
   import tlb_refill_walker_pkg::*;
#(
   parameter int ENTRY_ADDR_WIDTH = 3
) (
   input  logic        clk,
   input  logic        res,
   input  logic        missValid,
   input  logic [31:0] missVAddr,
   input  logic [7:0]  missAsid,
   input  logic [31:0] ptBase,
   output logic        busy,
   output logic        refillDone,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   output MMU_CMD_T    mmu_cmd,
   output MMU_REG_T    mmu_reg,
   output logic [31:0] mmu_dataIn
);

   localparam int W = ENTRY_ADDR_WIDTH;

   localparam logic [3:0] S_FLUSH_HI   = 4'd0;
   localparam logic [3:0] S_FLUSH_MASK = 4'd1;
   localparam logic [3:0] S_FLUSH_LO0  = 4'd2;
   localparam logic [3:0] S_FLUSH_LO1  = 4'd3;
   localparam logic [3:0] S_FLUSH_IDX  = 4'd4;
   localparam logic [3:0] S_FLUSH_WR   = 4'd5;
   localparam logic [3:0] S_IDLE       = 4'd6;
   localparam logic [3:0] S_RD_LO0     = 4'd7;
   localparam logic [3:0] S_RD_LO1     = 4'd8;
   localparam logic [3:0] S_W_IDX      = 4'd9;
   localparam logic [3:0] S_W_HI       = 4'd10;
   localparam logic [3:0] S_W_MASK     = 4'd11;
   localparam logic [3:0] S_W_LO0      = 4'd12;
   localparam logic [3:0] S_W_LO1      = 4'd13;
   localparam logic [3:0] S_W_TLB      = 4'd14;
   localparam logic [3:0] S_DONE       = 4'd15;

   logic [3:0]   state_q,     state_d;
   logic [W-1:0] flush_cnt_q, flush_cnt_d;
   logic [W-1:0] repl_idx_q,  repl_idx_d;
   logic [18:0]  vpn_q,       vpn_d;
   logic [7:0]   asid_q,      asid_d;
   logic [31:0]  pte_q,       pte_d;
   logic [31:0]  lo0_q,       lo0_d;
   logic [31:0]  lo1_q,       lo1_d;

   // Page offset bits never reach the TLB; only the VPN pair number matters.
   logic unused_vaddr_lo;
   assign unused_vaddr_lo = ^missVAddr[12:0];

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      repl_idx_d  = repl_idx_q;
      vpn_d       = vpn_q;
      asid_d      = asid_q;
      pte_d       = pte_q;
      lo0_d       = lo0_q;
      lo1_d       = lo1_q;
      case (state_q)
         S_FLUSH_HI:   state_d = S_FLUSH_MASK;
         S_FLUSH_MASK: state_d = S_FLUSH_LO0;
         S_FLUSH_LO0:  state_d = S_FLUSH_LO1;
         S_FLUSH_LO1:  state_d = S_FLUSH_IDX;
         S_FLUSH_IDX:  state_d = S_FLUSH_WR;
         S_FLUSH_WR: begin
            flush_cnt_d = flush_cnt_q + W'(1);
            state_d     = (flush_cnt_q == '1) ? S_IDLE : S_FLUSH_IDX;
         end
         S_IDLE: begin
            if (missValid) begin
               vpn_d   = missVAddr[31:13];
               asid_d  = missAsid;
               pte_d   = ptBase + {10'd0, missVAddr[31:13], 3'b000};
               state_d = S_RD_LO0;
            end
         end
         S_RD_LO0: begin
            if (mem_ready) begin
               lo0_d   = mem_data;
               state_d = S_RD_LO1;
            end
         end
         S_RD_LO1: begin
            if (mem_ready) begin
               lo1_d   = mem_data;
               state_d = S_W_IDX;
            end
         end
         S_W_IDX:  state_d = S_W_HI;
         S_W_HI:   state_d = S_W_MASK;
         S_W_MASK: state_d = S_W_LO0;
         S_W_LO0:  state_d = S_W_LO1;
         S_W_LO1:  state_d = S_W_TLB;
         S_W_TLB: begin
            repl_idx_d = repl_idx_q + W'(1);
            state_d    = S_DONE;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_FLUSH_HI;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q     <= S_FLUSH_HI;
         flush_cnt_q <= '0;
         repl_idx_q  <= '0;
         vpn_q       <= '0;
         asid_q      <= '0;
         pte_q       <= '0;
         lo0_q       <= '0;
         lo1_q       <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         repl_idx_q  <= repl_idx_d;
         vpn_q       <= vpn_d;
         asid_q      <= asid_d;
         pte_q       <= pte_d;
         lo0_q       <= lo0_d;
         lo1_q       <= lo1_d;
      end
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      refillDone = (state_q == S_DONE);
      mem_req    = (state_q == S_RD_LO0) || (state_q == S_RD_LO1);
      mem_addr   = '0;
      mmu_cmd    = MMU_CMD_WRITE_REG;
      mmu_reg    = MMU_REG_INDEX;
      mmu_dataIn = '0;
      case (state_q)
         S_FLUSH_HI:   mmu_reg = MMU_REG_ENTRYHI;
         S_FLUSH_MASK: mmu_reg = MMU_REG_PAGEMASK;
         S_FLUSH_LO0:  mmu_reg = MMU_REG_ENTRYLO0;
         S_FLUSH_LO1:  mmu_reg = MMU_REG_ENTRYLO1;
         S_FLUSH_IDX:  mmu_dataIn = 32'(flush_cnt_q);
         S_FLUSH_WR:   mmu_cmd = MMU_CMD_WRITE_TLB;
         S_RD_LO0: begin
            mmu_cmd  = MMU_CMD_NONE;
            mem_addr = pte_q;
         end
         S_RD_LO1: begin
            mmu_cmd  = MMU_CMD_NONE;
            mem_addr = pte_q + 32'd4;
         end
         S_W_IDX:  mmu_dataIn = 32'(repl_idx_q);
         S_W_HI: begin
            mmu_reg    = MMU_REG_ENTRYHI;
            mmu_dataIn = {vpn_q, 5'd0, asid_q};
         end
         S_W_MASK: mmu_reg = MMU_REG_PAGEMASK;
         S_W_LO0: begin
            mmu_reg    = MMU_REG_ENTRYLO0;
            mmu_dataIn = lo0_q;
         end
         S_W_LO1: begin
            mmu_reg    = MMU_REG_ENTRYLO1;
            mmu_dataIn = lo1_q;
         end
         S_W_TLB:  mmu_cmd = MMU_CMD_WRITE_TLB;
         default:  mmu_cmd = MMU_CMD_NONE;
      endcase
      // The reset state is FLUSH_HI, but its register write must not reach the MMU until reset is released.
      if (res) begin
         mmu_cmd    = MMU_CMD_NONE;
         mmu_reg    = MMU_REG_INDEX;
         mmu_dataIn = '0;
      end
   end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: checks the MMU command stream and memory
// handshake cycle by cycle against hand-computed values.
module tb_tlb_refill_walker;
   import tlb_refill_walker_pkg::*;

   logic        clk;
   logic        res;
   logic        missValid;
   logic [31:0] missVAddr;
   logic [7:0]  missAsid;
   logic [31:0] ptBase;
   logic        busy;
   logic        refillDone;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_data;
   MMU_CMD_T    mmu_cmd;
   MMU_REG_T    mmu_reg;
   logic [31:0] mmu_dataIn;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   tlb_refill_walker #(.ENTRY_ADDR_WIDTH(3)) dut (
      .clk        (clk),
      .res        (res),
      .missValid  (missValid),
      .missVAddr  (missVAddr),
      .missAsid   (missAsid),
      .ptBase     (ptBase),
      .busy       (busy),
      .refillDone (refillDone),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_data   (mem_data),
      .mmu_cmd    (mmu_cmd),
      .mmu_reg    (mmu_reg),
      .mmu_dataIn (mmu_dataIn)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to measure refill latency independently of the step sequence.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Drives the requester-side inputs in one call.
   task automatic applyStimulus(input logic valid, input logic [31:0] vaddr,
                                input logic [7:0] asid, input logic [31:0] base);
      missValid = valid;
      missVAddr = vaddr;
      missAsid  = asid;
      ptBase    = base;
   endtask

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Checks one MMU command; register and data only matter for register writes.
   task automatic checkCmd(input string tag, input MMU_CMD_T cmd,
                           input MMU_REG_T r, input logic [31:0] d);
      checkOutput({tag, ".cmd"}, 32'(mmu_cmd), 32'(cmd));
      if (cmd == MMU_CMD_WRITE_REG) begin
         checkOutput({tag, ".reg"}, 32'(mmu_reg), 32'(r));
         checkOutput({tag, ".data"}, mmu_dataIn, d);
      end
   endtask

   // Called in the first cycle after reset release; ends in the first IDLE cycle.
   task automatic checkFlush(input string tag);
      MMU_REG_T zeroRegs [4];
      zeroRegs = '{MMU_REG_ENTRYHI, MMU_REG_PAGEMASK, MMU_REG_ENTRYLO0, MMU_REG_ENTRYLO1};
      for (int i = 0; i < 4; i++) begin
         checkCmd($sformatf("%s.zero%0d", tag, i), MMU_CMD_WRITE_REG, zeroRegs[i], 32'd0);
         checkOutput($sformatf("%s.zero%0d.busy", tag, i), busy, 1'b1);
         checkOutput($sformatf("%s.zero%0d.req", tag, i), mem_req, 1'b0);
         @(negedge clk);
      end
      for (int k = 0; k < 8; k++) begin
         checkCmd($sformatf("%s.idx%0d", tag, k), MMU_CMD_WRITE_REG, MMU_REG_INDEX, 32'(k));
         checkOutput($sformatf("%s.idx%0d.req", tag, k), mem_req, 1'b0);
         @(negedge clk);
         checkCmd($sformatf("%s.wr%0d", tag, k), MMU_CMD_WRITE_TLB, MMU_REG_INDEX, 32'd0);
         checkOutput($sformatf("%s.wr%0d.busy", tag, k), busy, 1'b1);
         @(negedge clk);
      end
      checkOutput({tag, ".idle.busy"}, busy, 1'b0);
      checkCmd({tag, ".idle"}, MMU_CMD_NONE, MMU_REG_INDEX, 32'd0);
   endtask

   // Runs one refill from an IDLE cycle through DONE, ending in the following IDLE cycle.
   task automatic doRefill(input string tag, input logic [31:0] vaddr, input logic [7:0] asid,
                           input logic [31:0] base, input logic [31:0] expAddr,
                           input logic [31:0] expHi, input logic [31:0] lo0,
                           input logic [31:0] lo1, input int waits,
                           input logic [31:0] expIdx, input int expLat);
      int startCount;
      checkOutput({tag, ".idle.busy"}, busy, 1'b0);
      checkOutput({tag, ".idle.done"}, refillDone, 1'b0);
      startCount = cycleCount;
      applyStimulus(1'b1, vaddr, asid, base);
      @(negedge clk);
      for (int rd = 0; rd < 2; rd++) begin
         for (int w = 0; w <= waits; w++) begin
            checkOutput($sformatf("%s.rd%0d.w%0d.req", tag, rd, w), mem_req, 1'b1);
            checkOutput($sformatf("%s.rd%0d.w%0d.addr", tag, rd, w), mem_addr, expAddr + 32'(rd * 4));
            checkOutput($sformatf("%s.rd%0d.w%0d.cmd", tag, rd, w), 32'(mmu_cmd), 32'(MMU_CMD_NONE));
            if (w == waits) begin
               mem_ready = 1'b1;
               mem_data  = (rd == 0) ? lo0 : lo1;
            end else begin
               mem_ready = 1'b0;
               mem_data  = 32'hBAD0_BAD0;
            end
            @(negedge clk);
         end
      end
      mem_ready = 1'b0;
      mem_data  = 32'h0;
      checkOutput({tag, ".wIdx.req"}, mem_req, 1'b0);
      checkCmd({tag, ".wIdx"}, MMU_CMD_WRITE_REG, MMU_REG_INDEX, expIdx);
      @(negedge clk);
      checkCmd({tag, ".wHi"}, MMU_CMD_WRITE_REG, MMU_REG_ENTRYHI, expHi);
      @(negedge clk);
      checkCmd({tag, ".wMask"}, MMU_CMD_WRITE_REG, MMU_REG_PAGEMASK, 32'd0);
      @(negedge clk);
      checkCmd({tag, ".wLo0"}, MMU_CMD_WRITE_REG, MMU_REG_ENTRYLO0, lo0);
      @(negedge clk);
      checkCmd({tag, ".wLo1"}, MMU_CMD_WRITE_REG, MMU_REG_ENTRYLO1, lo1);
      @(negedge clk);
      checkCmd({tag, ".wTlb"}, MMU_CMD_WRITE_TLB, MMU_REG_INDEX, 32'd0);
      checkOutput({tag, ".wTlb.done"}, refillDone, 1'b0);
      @(negedge clk);
      checkOutput({tag, ".done"}, refillDone, 1'b1);
      checkOutput({tag, ".done.busy"}, busy, 1'b1);
      checkOutput({tag, ".done.cmd"}, 32'(mmu_cmd), 32'(MMU_CMD_NONE));
      checkOutput({tag, ".latency"}, 32'(cycleCount - startCount), 32'(expLat));
      missValid = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".after.done"}, refillDone, 1'b0);
      checkOutput({tag, ".after.busy"}, busy, 1'b0);
   endtask

   initial begin
      $display("[TB] tb_tlb_refill_walker starting");
      res       = 1'b1;
      mem_ready = 1'b0;
      mem_data  = 32'h0;
      applyStimulus(1'b0, 32'h0, 8'h0, 32'h0);
      repeat (2) @(negedge clk);

      checkOutput("rst.cmd", 32'(mmu_cmd), 32'(MMU_CMD_NONE));
      checkOutput("rst.reg", 32'(mmu_reg), 32'(MMU_REG_INDEX));
      checkOutput("rst.data", mmu_dataIn, 32'h0);
      checkOutput("rst.req", mem_req, 1'b0);
      checkOutput("rst.addr", mem_addr, 32'h0);
      checkOutput("rst.busy", busy, 1'b1);
      checkOutput("rst.done", refillDone, 1'b0);

      // A miss raised during the flush must wait until IDLE.
      applyStimulus(1'b1, 32'h0000_6000, 8'h01, 32'h0000_1000);
      res = 1'b0;
      #1;
      checkFlush("flush");

      doRefill("r0", 32'h0000_6000, 8'h01, 32'h0000_1000, 32'h0000_1018, 32'h0000_6001,
               32'h0000_1182, 32'h0000_1402, 0, 32'd0, 9);
      doRefill("r1wait", 32'h0000_6000, 8'h01, 32'h0000_1000, 32'h0000_1018, 32'h0000_6001,
               32'h0000_1182, 32'h0000_1402, 3, 32'd1, 15);
      // Table address wraps modulo 2^32; page-offset bits are dropped from ENTRYHI.
      doRefill("r2wrap", 32'h0000_2ABC, 8'hA5, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_20A5,
               32'h0000_0047, 32'h0000_0087, 1, 32'd2, 11);
      for (int i = 3; i < 9; i++) begin
         doRefill($sformatf("r%0d", i), 32'h0001_0000 + 32'(i) * 32'h2000, 8'(i),
                  32'h0000_1000, 32'h0000_1040 + 32'(i) * 32'd8,
                  32'h0001_0000 + 32'(i) * 32'h2000 + 32'(i),
                  32'h0000_1000 + 32'(i), 32'h0000_2000 + 32'(i), 0, 32'(i % 8), 9);
      end

      // Reset in the middle of the second read.
      applyStimulus(1'b1, 32'h0000_6000, 8'h01, 32'h0000_1000);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_data  = 32'h0000_1182;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("mid.req", mem_req, 1'b1);
      checkOutput("mid.addr", mem_addr, 32'h0000_101C);
      res = 1'b1;
      #1;
      checkOutput("midrst.req", mem_req, 1'b0);
      checkOutput("midrst.cmd", 32'(mmu_cmd), 32'(MMU_CMD_NONE));
      checkOutput("midrst.busy", busy, 1'b1);
      mem_ready = 1'b1;
      mem_data  = 32'h0000_1402;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_data  = 32'h0;
      missValid = 1'b0;
      res       = 1'b0;
      #1;
      checkFlush("reflush");

      doRefill("rAfterRst", 32'h0000_6000, 8'h01, 32'h0000_1000, 32'h0000_1018, 32'h0000_6001,
               32'h0000_1182, 32'h0000_1402, 0, 32'd0, 9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
